// File: rtl/timer_evt_ctrl.sv
// timer_evt_ctrl: event and interrupt stage behind the one-shot up-counter.
// Turns the live counter value into one-cycle expiry and compare pulses.
// It also keeps sticky status and overrun flags, a maskable interrupt and a
// saturating expiry counter. Status is cleared by write-1-to-clear pulses.
module timer_evt_ctrl #(
    parameter int WIDTH     = 32,
    parameter int EVT_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     cnt,
    input  logic [WIDTH-1:0]     cfg_max,
    input  logic [WIDTH-1:0]     cmp_val,
    input  logic [1:0]           irq_en,
    input  logic [1:0]           clr,
    output logic                 running,
    output logic                 expire_pulse,
    output logic                 cmp_pulse,
    output logic [1:0]           status,
    output logic [1:0]           ovr,
    output logic                 irq,
    output logic [EVT_CNT_W-1:0] expire_count
);

    // Raw conditions and their rising edges.
    logic       exp_c;
    logic       cmp_c;
    logic       exp_evt;
    logic       cmp_evt;
    logic [1:0] evt;

    // Registered state.
    logic                 exp_cond_q;
    logic                 cmp_cond_q;
    logic                 running_q;
    logic                 expire_pulse_q;
    logic                 cmp_pulse_q;
    logic [1:0]           status_q;
    logic [1:0]           ovr_q;
    logic [EVT_CNT_W-1:0] expire_count_q;

    // Next-state values.
    logic [1:0]           status_d;
    logic [1:0]           ovr_d;
    logic [EVT_CNT_W-1:0] expire_count_d;

    // Expiry matches the up-counter's stop condition; cfg_max = 0 then
    // behaves like 1 because cnt != 0 is required anyway.
    assign exp_c   = (cnt != '0) && (cnt >= cfg_max);
    // A zero threshold disables the compare channel.
    assign cmp_c   = (cmp_val != '0) && (cnt == cmp_val);
    // Only the first cycle of a held condition counts as an event.
    assign exp_evt = exp_c && !exp_cond_q;
    assign cmp_evt = cmp_c && !cmp_cond_q;
    assign evt     = {cmp_evt, exp_evt};

    // Next-state for sticky flags and the saturating expiry counter.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        status_d       = status_q;
        ovr_d          = ovr_q;
        expire_count_d = expire_count_q;

        for (int i = 0; i < 2; i++) begin
            // The clear acts first; an event in the same cycle then lands
            // in an empty slot, so status ends set and ovr ends clear.
            if (clr[i]) begin
                status_d[i] = 1'b0;
                ovr_d[i]    = 1'b0;
            end
            if (evt[i]) begin
                if (status_d[i]) begin
                    ovr_d[i] = 1'b1;
                end
                status_d[i] = 1'b1;
            end
        end

        if (clr[0]) begin
            expire_count_d = '0;
        end
        // Saturate at all-ones instead of wrapping.
        if (exp_evt && (expire_count_d != {EVT_CNT_W{1'b1}})) begin
            expire_count_d = expire_count_d + 1'b1;
        end
    end

    // State registers; synchronous reset wins over any event or clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            exp_cond_q     <= 1'b0;
            cmp_cond_q     <= 1'b0;
            running_q      <= 1'b0;
            expire_pulse_q <= 1'b0;
            cmp_pulse_q    <= 1'b0;
            status_q       <= '0;
            ovr_q          <= '0;
            expire_count_q <= '0;
        end else begin
            exp_cond_q     <= exp_c;
            cmp_cond_q     <= cmp_c;
            running_q      <= (cnt != '0);
            expire_pulse_q <= exp_evt;
            cmp_pulse_q    <= cmp_evt;
            status_q       <= status_d;
            ovr_q          <= ovr_d;
            expire_count_q <= expire_count_d;
        end
    end

    assign running      = running_q;
    assign expire_pulse = expire_pulse_q;
    assign cmp_pulse    = cmp_pulse_q;
    assign status       = status_q;
    assign ovr          = ovr_q;
    assign expire_count = expire_count_q;
    // The mask is applied after the flags, so irq_en takes effect at once
    // and never alters the sticky status.
    assign irq          = |(status_q & irq_en);

endmodule
